// File: rtl/spi_target_bridge.sv
// SPI mode-0 target that turns host frames into word-aligned 32-bit bus reads and writes.
// state   | meaning
// IDLE    | CS high, waiting for a frame
// CMD     | shifting in the command byte
// ADDR    | shifting in the 4-byte big-endian address
// WDATA   | shifting in write words, one bus write per 4 bytes
// RDUMMY  | dummy byte while the first read is in flight
// RDATA   | shifting out prefetched read words
// IGNORE  | unknown command, absorb bits until CS rises
module spi_target_bridge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sck_in,
  input  logic        spi_cs_n_in,
  input  logic        spi_mosi_in,
  output logic        spi_miso_out,
  output logic        spi_miso_oe,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  output logic        bus_we,
  output logic        bus_re,
  input  logic        bus_busy,
  output logic        active,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WDATA, S_RDUMMY, S_RDATA, S_IGNORE
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic sck_d, cs_d;
  logic sck_s, cs_s, mosi_s;

  logic [2:0]  bit_cnt;
  logic [1:0]  byte_cnt;
  logic [7:0]  shift_in;
  logic [23:0] word_acc;
  logic        is_read;
  logic [31:0] cur_addr;
  logic [31:0] pf;
  logic        pf_valid;
  logic        rd_discard;
  logic        load_pending;
  logic [30:0] sh;
  logic        miso;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck_in};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n_in};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_in};
      sck_d     <= sck_s;
      cs_d      <= cs_s;
    end
  end

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  logic sck_rise, sck_fall, cs_fall, cs_rise, in_frame;
  logic bit_rise, bit_fall, byte_done, word_done;
  logic [7:0]  byte_val;
  logic [31:0] full_word, addr_aligned, launch_addr;
  logic xfer, rd_req, rd_go, wr_word, req_done;

  assign sck_rise  = sck_s & ~sck_d;
  assign sck_fall  = ~sck_s & sck_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign in_frame  = (state != S_IDLE) & ~cs_s;
  assign bit_rise  = sck_rise & in_frame;
  assign bit_fall  = sck_fall & in_frame;
  assign byte_val  = {shift_in[6:0], mosi_s};
  assign byte_done = bit_rise & (bit_cnt == 3'd7);
  assign word_done = byte_done & (byte_cnt == 2'd3);

  assign full_word    = {word_acc, byte_val};
  assign addr_aligned = {full_word[31:2], 2'b00};
  assign launch_addr  = (state == S_ADDR) ? addr_aligned : cur_addr;

  // A missed transfer with the read still outstanding lets that read feed the next word.
  assign xfer     = bit_fall & (state == S_RDATA) & load_pending;
  assign rd_req   = (word_done & (state == S_ADDR) & is_read) | (xfer & (pf_valid | ~bus_re));
  assign rd_go    = rd_req & ~bus_re & ~bus_we;
  assign wr_word  = word_done & (state == S_WDATA);
  assign req_done = (bus_re | bus_we) & ~bus_busy;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (cs_rise) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (cs_fall) state_nxt = S_CMD;
        S_CMD:    if (byte_done)
                    state_nxt = (byte_val == 8'h02 || byte_val == 8'h03) ? S_ADDR : S_IGNORE;
        S_ADDR:   if (word_done) state_nxt = is_read ? S_RDUMMY : S_WDATA;
        S_RDUMMY: if (byte_done) state_nxt = S_RDATA;
        default:  state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active       <= 1'b0;
      err          <= 1'b0;
      bit_cnt      <= '0;
      byte_cnt     <= '0;
      shift_in     <= '0;
      word_acc     <= '0;
      is_read      <= 1'b0;
      cur_addr     <= '0;
      pf           <= '0;
      pf_valid     <= 1'b0;
      rd_discard   <= 1'b0;
      load_pending <= 1'b0;
      sh           <= '0;
      miso         <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      bus_we       <= 1'b0;
      bus_re       <= 1'b0;
    end else begin
      active <= ~cs_s;

      if (bit_rise) begin
        shift_in <= byte_val;
        bit_cnt  <= bit_cnt + 3'd1;
      end
      if (byte_done) begin
        word_acc <= {word_acc[15:0], byte_val};
        byte_cnt <= (state_nxt != state) ? 2'd0 : byte_cnt + 2'd1;
      end
      if (byte_done && state == S_CMD) is_read <= (byte_val == 8'h03);
      if (word_done && state == S_ADDR) cur_addr <= addr_aligned;

      if (req_done) begin
        bus_we <= 1'b0;
        bus_re <= 1'b0;
        if (bus_re) begin
          if (!rd_discard) begin
            pf       <= bus_rdata;
            pf_valid <= 1'b1;
          end
          rd_discard <= 1'b0;
        end
      end

      if (rd_go) begin
        bus_re   <= 1'b1;
        bus_addr <= launch_addr;
        cur_addr <= launch_addr + 32'd4;
      end

      if (wr_word) begin
        if (bus_we || bus_re) begin
          err <= 1'b1;
        end else begin
          bus_we    <= 1'b1;
          bus_wdata <= full_word;
          bus_addr  <= cur_addr;
          cur_addr  <= cur_addr + 32'd4;
        end
      end

      if ((byte_done && state == S_RDUMMY) || (word_done && state == S_RDATA))
        load_pending <= 1'b1;

      if (bit_fall) begin
        if (state == S_RDATA) begin
          if (load_pending) begin
            load_pending <= 1'b0;
            if (pf_valid) begin
              sh       <= pf[30:0];
              miso     <= pf[31];
              pf_valid <= 1'b0;
            end else begin
              err  <= 1'b1;
              sh   <= '1;
              miso <= 1'b1;
            end
          end else begin
            sh   <= {sh[29:0], 1'b0};
            miso <= sh[30];
          end
        end else begin
          miso <= 1'b0;
        end
      end

      if (cs_rise) begin
        pf_valid     <= 1'b0;
        load_pending <= 1'b0;
        if (bus_re && !req_done) rd_discard <= 1'b1;
      end

      if (cs_fall) begin
        bit_cnt  <= '0;
        byte_cnt <= '0;
        err      <= 1'b0;
      end
    end
  end

  assign spi_miso_out = miso;
  assign spi_miso_oe  = ~cs_s;

endmodule

// File: tb/tb_spi_target_bridge.sv
// Bench for spi_target_bridge: bit-banged SPI host, bus responder with memory, frame-level reference model.
module tb_spi_target_bridge;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_sck_in, spi_cs_n_in, spi_mosi_in;
  logic        spi_miso_out, spi_miso_oe;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_we, bus_re;
  logic        bus_busy = 1'b0;
  logic        active, err;

  spi_target_bridge #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .spi_sck_in(spi_sck_in), .spi_cs_n_in(spi_cs_n_in), .spi_mosi_in(spi_mosi_in),
    .spi_miso_out(spi_miso_out), .spi_miso_oe(spi_miso_oe),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_we(bus_we), .bus_re(bus_re), .bus_busy(bus_busy),
    .active(active), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  logic [31:0] mem [0:255];
  assign bus_rdata = mem[bus_addr[9:2]];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          len;
  } wr_t;

  wr_t         wr_q[$];
  logic [31:0] rd_q[$];
  int          req_len = 0;
  int          busy_arm = 0;
  bit          force_busy = 0;
  bit          expect_drop = 0;
  bit          viol_both = 0, viol_stable = 0, viol_drop = 0, viol_align = 0;
  logic [31:0] cap_addr, cap_wdata;

  // Responder: decides bus_busy for the coming edge and logs the transfers that complete on it.
  always @(negedge clk) begin
    wr_t w;
    if (bus_we && bus_re) viol_both = 1;
    if (expect_drop && (bus_we || bus_re)) viol_drop = 1;
    expect_drop = 0;
    if (bus_we || bus_re) begin
      if (bus_addr[1:0] != 2'b00) viol_align = 1;
      if (req_len == 0) begin
        cap_addr  = bus_addr;
        cap_wdata = bus_wdata;
      end else if (bus_addr !== cap_addr || (bus_we && bus_wdata !== cap_wdata)) begin
        viol_stable = 1;
      end
      req_len++;
      if (force_busy) begin
        bus_busy = 1'b1;
      end else if (busy_arm > 0) begin
        bus_busy = 1'b1;
        busy_arm--;
      end else begin
        bus_busy = 1'b0;
        if (bus_we) begin
          w.addr = bus_addr; w.data = bus_wdata; w.len = req_len;
          wr_q.push_back(w);
          mem[bus_addr[9:2]] = bus_wdata;
        end else begin
          rd_q.push_back(bus_addr);
        end
        req_len     = 0;
        expect_drop = 1;
      end
    end else begin
      req_len  = 0;
      bus_busy = force_busy;
    end
  end

  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  logic [31:0] wq[$];

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi_in = tx[i];
      repeat (HALF) @(negedge clk);
      rx[i] = spi_miso_out;
      spi_sck_in = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sck_in = 1'b0;
    end
  endtask

  task automatic run_frame();
    logic [7:0] b;
    rx_q = {};
    wr_q = {};
    rd_q = {};
    spi_cs_n_in = 1'b0;
    repeat (HALF) @(negedge clk);
    check_val("active_in_frame", {31'b0, active}, 32'd1);
    check_val("oe_in_frame", {31'b0, spi_miso_oe}, 32'd1);
    check_val("err_cleared", {31'b0, err}, 32'd0);
    foreach (tx_q[i]) begin
      spi_byte(tx_q[i], b);
      rx_q.push_back(b);
    end
    repeat (HALF) @(negedge clk);
    spi_cs_n_in = 1'b1;
    repeat (4 * HALF) @(negedge clk);
  endtask

  task automatic push_word(input logic [31:0] w);
    tx_q.push_back(w[31:24]); tx_q.push_back(w[23:16]);
    tx_q.push_back(w[15:8]);  tx_q.push_back(w[7:0]);
  endtask

  // Expected writes: one per complete word, consecutive word addresses wrapping at 2^32.
  task automatic do_write(input logic [31:0] addr, input int partial, input int first_len);
    logic [31:0] base;
    base = {addr[31:2], 2'b00};
    tx_q = {};
    tx_q.push_back(8'h02);
    push_word(addr);
    foreach (wq[i]) push_word(wq[i]);
    for (int i = 0; i < partial; i++) tx_q.push_back(8'($urandom));
    run_frame();
    check_val("wr_count", wr_q.size(), wq.size());
    for (int k = 0; k < wq.size() && k < wr_q.size(); k++) begin
      check_val("wr_addr", wr_q[k].addr, base + 32'(4 * k));
      check_val("wr_data", wr_q[k].data, wq[k]);
      check_val("wr_len", wr_q[k].len, (k == 0) ? first_len : 1);
    end
    check_val("wr_err", {31'b0, err}, 32'd0);
  endtask

  task automatic do_read(input logic [31:0] addr, input int nw, input bit starve);
    logic [31:0] base, exp_w, got_w;
    logic [31:0] exp_q[$];
    base  = {addr[31:2], 2'b00};
    exp_q = {};
    for (int k = 0; k < nw; k++) begin
      exp_w = base + 32'(4 * k);
      exp_q.push_back(starve ? 32'hFFFF_FFFF : mem[exp_w[9:2]]);
    end
    tx_q = {};
    tx_q.push_back(8'h03);
    push_word(addr);
    for (int i = 0; i < 4 * nw + 1; i++) tx_q.push_back(8'($urandom));
    force_busy = starve;
    run_frame();
    for (int k = 0; k < nw; k++) begin
      got_w = {rx_q[6 + 4*k], rx_q[7 + 4*k], rx_q[8 + 4*k], rx_q[9 + 4*k]};
      check_val("rd_miso_word", got_w, exp_q[k]);
    end
    check_val("rd_err", {31'b0, err}, {31'b0, starve});
    if (!starve) begin
      check_val("rd_enough", {31'b0, rd_q.size() >= nw}, 32'd1);
      for (int k = 0; k < nw && k < rd_q.size(); k++)
        check_val("rd_addr", rd_q[k], base + 32'(4 * k));
    end
    force_busy = 0;
    repeat (4 * HALF) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_miso"}, {31'b0, spi_miso_out}, 32'd0);
    check_val({tag, "_oe"}, {31'b0, spi_miso_oe}, 32'd0);
    check_val({tag, "_we_re"}, {30'b0, bus_we, bus_re}, 32'd0);
    check_val({tag, "_addr"}, bus_addr, 32'd0);
    check_val({tag, "_wdata"}, bus_wdata, 32'd0);
    check_val({tag, "_active_err"}, {30'b0, active, err}, 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] c;
    int op;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    rst = 1'b1;
    spi_sck_in = 1'b0; spi_cs_n_in = 1'b1; spi_mosi_in = 1'b0;
    repeat (4) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    wq = {32'hDEAD_BEEF};
    do_write(32'h0000_0100, 0, 1);

    mem[32'h200 >> 2] = 32'h1234_5678;
    mem[32'h204 >> 2] = 32'hCAFE_F00D;
    do_read(32'h0000_0200, 2, 0);

    busy_arm = 3;
    wq = {32'hA5A5_0F0F};
    do_write(32'h0000_0300, 0, 4);

    do_read(32'h0000_0040, 1, 1);

    wq = {32'h1111_2222, 32'h3333_4444};
    do_write(32'hFFFF_FFFC, 0, 1);

    wq = {};
    do_write(32'h0000_0500, 2, 1);

    // Reset in the middle of a write frame, then release with CS already high.
    tx_q = {8'h02, 8'h00, 8'h00, 8'h06, 8'h00, 8'h77};
    wr_q = {};
    spi_cs_n_in = 1'b0;
    repeat (HALF) @(negedge clk);
    foreach (tx_q[i]) spi_byte(tx_q[i], b);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("midrst");
    rst = 1'b0;
    spi_cs_n_in = 1'b1;
    repeat (5 * HALF) @(negedge clk);
    check_val("midrst_no_write", wr_q.size(), 32'd0);
    check_val("midrst_idle", {31'b0, active}, 32'd0);

    wq = {32'h0BAD_CAFE};
    do_write(32'h0000_0600, 0, 1);

    for (int it = 0; it < 8; it++) begin
      op = $urandom_range(0, 3);
      if (op <= 1) begin
        wq = {};
        for (int k = 0, n = $urandom_range(1, 3); k < n; k++) wq.push_back($urandom);
        do_write($urandom, $urandom_range(0, 3), 1);
      end else if (op == 2) begin
        do_read($urandom, $urandom_range(1, 2), 0);
      end else begin
        do c = 8'($urandom); while (c == 8'h02 || c == 8'h03);
        tx_q = {c};
        for (int i = 0; i < 9; i++) tx_q.push_back(8'($urandom));
        run_frame();
        check_val("ignore_no_bus", wr_q.size() + rd_q.size(), 32'd0);
      end
    end

    check_val("never_we_and_re", {31'b0, viol_both}, 32'd0);
    check_val("req_stable", {31'b0, viol_stable}, 32'd0);
    check_val("req_drops", {31'b0, viol_drop}, 32'd0);
    check_val("addr_aligned", {31'b0, viol_align}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
